usb_uart_stream_adapter: RTL and testbench

Sits directly downstream of usb_uart, on its byte-level UART-style port (uart_we/uart_re/uart_di/uart_do/uart_wait/uart_ready). It converts that pulse-and-flag handshake into two buffered valid/ready byte streams for user logic: RX for host to device, TX for device to host. Each direction has its own FIFO, so user logic can stall without losing bytes and can burst writes without watching uart_wait.

---
 rtl/usb_uart_stream_adapter.sv | 118 +++++++++++
 tb/tb_usb_uart_stream_adapter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_stream_adapter.sv
// usb_uart_stream_adapter: buffers the usb_uart strobe/flag byte port into RX and TX valid/ready FIFO streams.
module usb_uart_stream_adapter #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                     clk_48mhz,
    input  logic                     resetn,
    output logic                     uart_we,
    output logic [7:0]               uart_di,
    input  logic                     uart_wait,
    output logic                     uart_re,
    input  logic [7:0]               uart_do,
    input  logic                     uart_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [RX_DEPTH_LOG2:0]   rx_level,
    output logic [TX_DEPTH_LOG2:0]   tx_level
);
    typedef enum logic {R_IDLE, R_HOLD} rx_st_e;
    typedef enum logic {T_IDLE, T_HOLD} tx_st_e;
    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);
    logic [7:0]             rx_mem_q [1 << RX_DEPTH_LOG2];
    logic [7:0]             tx_mem_q [1 << TX_DEPTH_LOG2];
    logic [RX_DEPTH_LOG2:0] rx_wptr_q, rx_rptr_q;
    logic [TX_DEPTH_LOG2:0] tx_wptr_q, tx_rptr_q;
    rx_st_e                 rx_st_q, rx_st_d;
    tx_st_e                 tx_st_q, tx_st_d;
    logic [2:0]             rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                   re_q, re_d, we_q, we_d;
    logic [7:0]             di_q, di_d, tx_head;
    logic                   rx_push, rx_pop, rx_full, tx_push, tx_pop, tx_empty;
    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign rx_full  = rx_level[RX_DEPTH_LOG2];
    assign rx_valid = rx_wptr_q != rx_rptr_q;
    assign rx_data  = rx_valid ? rx_mem_q[rx_rptr_q[RX_DEPTH_LOG2-1:0]] : 8'd0;
    assign rx_pop   = rx_valid && rx_ready;
    assign tx_ready = !tx_level[TX_DEPTH_LOG2];
    assign tx_empty = tx_wptr_q == tx_rptr_q;
    assign tx_head  = tx_mem_q[tx_rptr_q[TX_DEPTH_LOG2-1:0]];
    assign tx_push  = tx_valid && tx_ready;
    assign uart_re  = re_q;
    assign uart_we  = we_q;
    assign uart_di  = di_q;
    // Hold counter starts at HOLD_CYCLES-1 so the strobe cycle counts as the first hold cycle.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        re_d     = 1'b0;
        rx_push  = 1'b0;
        if (rx_st_q == R_IDLE) begin
            if (uart_ready && !rx_full) begin
                rx_push  = 1'b1;
                re_d     = 1'b1;
                rx_cnt_d = HOLD_LAST;
                rx_st_d  = R_HOLD;
            end
        end else begin
            rx_cnt_d = (rx_cnt_q == 3'd0) ? 3'd0 : rx_cnt_q - 3'd1;
            rx_st_d  = (rx_cnt_q == 3'd0) ? R_IDLE : R_HOLD;
        end
    end
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        we_d     = 1'b0;
        di_d     = di_q;
        tx_pop   = 1'b0;
        if (tx_st_q == T_IDLE) begin
            if (!tx_empty && !uart_wait) begin
                tx_pop   = 1'b1;
                we_d     = 1'b1;
                di_d     = tx_head;
                tx_cnt_d = HOLD_LAST;
                tx_st_d  = T_HOLD;
            end
        end else begin
            tx_cnt_d = (tx_cnt_q == 3'd0) ? 3'd0 : tx_cnt_q - 3'd1;
            tx_st_d  = (tx_cnt_q == 3'd0) ? T_IDLE : T_HOLD;
        end
    end
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            rx_st_q   <= R_IDLE;
            tx_st_q   <= T_IDLE;
            rx_cnt_q  <= 3'd0;
            tx_cnt_q  <= 3'd0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            di_q      <= 8'd0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            rx_st_q   <= rx_st_d;
            tx_st_q   <= tx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            re_q      <= re_d;
            we_q      <= we_d;
            di_q      <= di_d;
            rx_wptr_q <= rx_wptr_q + {{RX_DEPTH_LOG2{1'b0}}, rx_push};
            rx_rptr_q <= rx_rptr_q + {{RX_DEPTH_LOG2{1'b0}}, rx_pop};
            tx_wptr_q <= tx_wptr_q + {{TX_DEPTH_LOG2{1'b0}}, tx_push};
            tx_rptr_q <= tx_rptr_q + {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
        end
    end
    always_ff @(posedge clk_48mhz) begin
        if (rx_push) rx_mem_q[rx_wptr_q[RX_DEPTH_LOG2-1:0]] <= uart_do;
        if (tx_push) tx_mem_q[tx_wptr_q[TX_DEPTH_LOG2-1:0]] <= tx_data;
    end
endmodule

// File: tb/tb_usb_uart_stream_adapter.sv
// tb_usb_uart_stream_adapter: directed bench with a behavioural bridge on the uart side.
module tb_usb_uart_stream_adapter;
    logic       clk_48mhz = 1'b0;
    logic       resetn, uart_we, uart_wait, uart_re, uart_ready;
    logic [7:0] uart_di, uart_do, rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [4:0] rx_level, tx_level;
    int         total = 0, bad = 0, cyc = 0, re_cnt = 0, we_viol = 0, dbl_viol = 0, push_cyc = 0;
    logic       prev_we = 1'b0, prev_re = 1'b0, tx_ok;
    logic [7:0] bq[$], wr_log[$], got[$];
    int         wr_cyc[$];

    always #5 clk_48mhz = ~clk_48mhz;

    usb_uart_stream_adapter #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .HOLD_CYCLES(2)) dut (
        .clk_48mhz(clk_48mhz), .resetn(resetn),
        .uart_we(uart_we), .uart_di(uart_di), .uart_wait(uart_wait),
        .uart_re(uart_re), .uart_do(uart_do), .uart_ready(uart_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_level(rx_level), .tx_level(tx_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bridge_drive();
        uart_ready = bq.size() != 0;
        uart_do    = (bq.size() != 0) ? bq[0] : 8'h00;
    endtask

    // One clock: the bridge consumes on a strobe seen at the edge and its flags lag by one cycle.
    task automatic tick();
        logic re_s, w_s;
        re_s = uart_re;
        w_s  = uart_wait;
        @(posedge clk_48mhz);
        #1;
        cyc++;
        if (re_s && bq.size() != 0) bq.delete(0);
        bridge_drive();
        if (uart_re) re_cnt++;
        if (uart_we) begin
            wr_log.push_back(uart_di);
            wr_cyc.push_back(cyc);
        end
        if (uart_we && w_s) we_viol++;
        if ((uart_we && prev_we) || (uart_re && prev_re)) dbl_viol++;
        prev_we = uart_we;
        prev_re = uart_re;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        if (!tx_ready) tx_ok = 1'b0;
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; uart_wait = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        bridge_drive();
        repeat (3) tick();
        chk("rst_we", uart_we, 1'b0);
        chk("rst_re", uart_re, 1'b0);
        chk("rst_di", uart_di, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_level", rx_level, 5'd0);
        chk("rst_tx_level", tx_level, 5'd0);
        resetn = 1'b1;
        tick();
        // single RX byte
        re_cnt = 0;
        bq.push_back(8'hA5);
        bridge_drive();
        tick();
        chk("rx_lat_valid", rx_valid, 1'b1);
        chk("rx_lat_re", uart_re, 1'b1);
        repeat (6) tick();
        chk("rx1_re_cnt", re_cnt, 1);
        chk("rx1_data", rx_data, 8'hA5);
        chk("rx1_valid", rx_valid, 1'b1);
        chk("rx1_level", rx_level, 5'd1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx1_pop_valid", rx_valid, 1'b0);
        chk("rx1_pop_level", rx_level, 5'd0);
        // TX burst with the bridge always ready
        wr_log.delete(); wr_cyc.delete(); tx_ok = 1'b1;
        push(8'h11);
        push_cyc = cyc;
        push(8'h22);
        push(8'h33);
        chk("tx3_ready_held", tx_ok, 1'b1);
        repeat (15) tick();
        chk("tx3_count", wr_log.size(), 3);
        chk("tx3_b0", wr_log[0], 8'h11);
        chk("tx3_b1", wr_log[1], 8'h22);
        chk("tx3_b2", wr_log[2], 8'h33);
        chk("tx3_latency", wr_cyc[0] - push_cyc, 1);
        chk("tx3_gap0", wr_cyc[1] - wr_cyc[0], 3);
        chk("tx3_gap1", wr_cyc[2] - wr_cyc[1], 3);
        chk("tx3_level", tx_level, 5'd0);
        // uart_wait stalls the remaining TX bytes
        wr_log.delete(); wr_cyc.delete();
        push(8'h44);
        push(8'h55);
        chk("tx_simul_level", tx_level, 5'd1);
        push(8'h66);
        for (int k = 0; k < 10 && wr_log.size() == 0; k++) tick();
        chk("wait_first_we", wr_log.size(), 1);
        uart_wait = 1'b1;
        repeat (20) tick();
        chk("wait_no_we", wr_log.size(), 1);
        chk("wait_level", tx_level, 5'd2);
        uart_wait = 1'b0;
        repeat (15) tick();
        chk("wait_count", wr_log.size(), 3);
        chk("wait_b0", wr_log[0], 8'h44);
        chk("wait_b1", wr_log[1], 8'h55);
        chk("wait_b2", wr_log[2], 8'h66);
        chk("wait_level_end", tx_level, 5'd0);
        // RX backpressure: 20 bytes into a 16-entry FIFO, then drain across the wrap
        re_cnt = 0;
        for (int i = 0; i < 20; i++) bq.push_back(8'(i));
        bridge_drive();
        repeat (70) tick();
        chk("rxf_level", rx_level, 5'd16);
        chk("rxf_re_cnt", re_cnt, 16);
        chk("rxf_bridge_left", bq.size(), 4);
        chk("rxf_re_idle", uart_re, 1'b0);
        chk("rxf_head", rx_data, 8'h00);
        rx_ready = 1'b1;
        for (int k = 0; k < 200 && got.size() < 20; k++) begin
            if (rx_valid) got.push_back(rx_data);
            tick();
        end
        rx_ready = 1'b0;
        chk("rxd_count", got.size(), 20);
        for (int i = 0; i < 20; i++) chk($sformatf("rxd_b%0d", i), got[i], 8'(i));
        chk("rxd_level", rx_level, 5'd0);
        chk("rxd_re_cnt", re_cnt, 20);
        // fill TX, then reset in the middle of a hold
        uart_wait = 1'b1;
        wr_log.delete(); wr_cyc.delete();
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("txf_ready", tx_ready, 1'b0);
        chk("txf_level", tx_level, 5'd16);
        push(8'hFF);
        chk("txf_push_when_full", tx_level, 5'd16);
        uart_wait = 1'b0;
        for (int k = 0; k < 10 && wr_log.size() == 0; k++) tick();
        chk("txr_first_we", wr_log.size(), 1);
        chk("txr_first_b", wr_log[0], 8'h80);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("txr_we", uart_we, 1'b0);
        chk("txr_level", tx_level, 5'd0);
        chk("txr_ready", tx_ready, 1'b1);
        repeat (10) tick();
        chk("txr_no_more_we", wr_log.size(), 1);
        chk("we_during_wait", we_viol, 0);
        chk("strobe_width", dbl_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
